// File: rtl/regfile_dumper.sv
// Debug sequencer that borrows the regfile ports to zero every register (CLEAR)
// or stream every {addr,data} pair out over a valid/ready port (DUMP).
module regfile_dumper #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int NREGS  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_clear,
    input  logic              start_dump,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        READ  = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_reg;
    logic [ADDR_W-1:0]  idx_reg;
    logic               out_valid_reg;
    logic [ADDR_W-1:0]  out_addr_reg;
    logic [DATA_W-1:0]  out_data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_addr_reg  <= '0;
            out_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    idx_reg <= '0;
                    // Clear has priority; a simultaneous dump request is dropped.
                    if (start_clear)
                        state_reg <= CLEAR;
                    else if (start_dump)
                        state_reg <= READ;
                end
                CLEAR: begin
                    if (idx_reg == LAST_IDX)
                        state_reg <= DONE;
                    else
                        idx_reg <= idx_reg + 1'b1;
                end
                READ: begin
                    out_data_reg  <= rf_rdata;
                    out_addr_reg  <= idx_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= DONE;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= READ;
                        end
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Port ownership is a pure decode of the registered state: outside the
    // owning states every borrowed regfile port is driven to zero.
    assign busy      = (state_reg == CLEAR) || (state_reg == READ) || (state_reg == SEND);
    assign done      = (state_reg == DONE);
    assign rf_we     = (state_reg == CLEAR);
    assign rf_waddr  = (state_reg == CLEAR) ? idx_reg : '0;
    assign rf_wdata  = '0;
    assign rf_addr   = ((state_reg == READ) || (state_reg == SEND)) ? idx_reg : '0;
    assign out_valid = out_valid_reg;
    assign out_addr  = out_addr_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: a behavioural regfile plus a per-register content
// model; dumps are compared word by word under random backpressure.
module tb_regfile_dumper;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int NREGS  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_clear;
    logic              start_dump;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    logic              pl_we;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;

    logic [DATA_W-1:0] mem   [NREGS];
    logic [DATA_W-1:0] model [NREGS];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_dumper #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset), .start_clear(start_clear), .start_dump(start_dump),
        .busy(busy), .done(done), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data)
    );

    // Behavioural regfile: combinational read, write on posedge.
    always @(posedge clk) begin
        if (rf_we)
            mem[rf_waddr] <= rf_wdata;
        else if (pl_we)
            mem[pl_addr] <= pl_data;
    end
    assign rf_rdata = mem[rf_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input bit pattern);
        for (int i = 0; i < NREGS; i++) begin
            pl_we   = 1'b1;
            pl_addr = ADDR_W'(i);
            pl_data = pattern ? (32'hA5A50000 + 32'(i)) : $urandom;
            model[i] = pl_data;
            step();
        end
        pl_we = 1'b0;
        step();
        $display("preload %s done", pattern ? "pattern" : "random");
    endtask

    task automatic run_clear(input bit both, input int poke);
        int we_n = 0;
        int vcnt = 0;
        int dones = 0;
        int done_at = -1;
        start_clear = 1'b1;
        start_dump  = both;
        step();
        start_clear = 1'b0;
        start_dump  = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            if (rf_we) begin
                check("clr_waddr", 64'(rf_waddr), 64'(we_n));
                check("clr_wdata", 64'(rf_wdata), 64'd0);
                check("clr_busy", 64'(busy), 64'd1);
                we_n++;
            end
            if (out_valid) vcnt++;
            if (done) begin
                dones++;
                done_at = c;
            end
            start_dump = (c == poke);
            step();
        end
        start_dump = 1'b0;
        check("clr_writes", 64'(we_n), 64'(NREGS));
        check("clr_done_cnt", 64'(dones), 64'd1);
        check("clr_done_cycle", 64'(done_at), 64'(NREGS + 1));
        check("clr_no_valid", 64'(vcnt), 64'd0);
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        $display("clear: both=%0d writes=%0d done_at=%0d valid_cycles=%0d", both, we_n, done_at, vcnt);
    endtask

    task automatic run_dump(input int ready_pct, input bit stall3);
        int n = 0;
        int dones = 0;
        int stall = 0;
        bit held = 1'b0;
        logic [ADDR_W-1:0] ha = '0;
        logic [DATA_W-1:0] hd = '0;
        start_dump = 1'b1;
        step();
        start_dump = 1'b0;
        check("dump_lat_read", 64'(out_valid), 64'd0);
        check("dump_busy", 64'(busy), 64'd1);
        step();
        check("dump_first_valid", 64'(out_valid), 64'd1);
        for (int c = 0; c < 3000 && dones == 0; c++) begin
            if (done) begin
                dones++;
                check("done_busy", 64'(busy), 64'd0);
                check("done_valid", 64'(out_valid), 64'd0);
            end else begin
                if (out_valid) begin
                    if (held) begin
                        check("hold_addr", 64'(out_addr), 64'(ha));
                        check("hold_data", 64'(out_data), 64'(hd));
                    end
                    check("send_rf_addr", 64'(rf_addr), 64'(out_addr));
                    if (stall3 && out_addr == 6'd3 && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = ($urandom_range(99) < 32'(ready_pct));
                    end
                    if (out_ready) begin
                        check("dump_addr", 64'(out_addr), 64'(n % NREGS));
                        check("dump_data", 64'(out_data), 64'(model[n % NREGS]));
                        n++;
                    end
                    held = !out_ready;
                    ha   = out_addr;
                    hd   = out_data;
                end else begin
                    out_ready = 1'($urandom_range(1));
                    held = 1'b0;
                end
                step();
            end
        end
        out_ready = 1'b0;
        check("dump_words", 64'(n), 64'(NREGS));
        check("dump_done_cnt", 64'(dones), 64'd1);
        if (stall3) check("dump_stall_len", 64'(stall), 64'd5);
        step();
        check("done_pulse_len", 64'(done), 64'd0);
        $display("dump: ready_pct=%0d stall3=%0d words=%0d dones=%0d", ready_pct, stall3, n, dones);
    endtask

    initial begin
        reset = 1'b1;
        start_clear = 1'b0;
        start_dump = 1'b0;
        out_ready = 1'b0;
        pl_we = 1'b0;
        pl_addr = '0;
        pl_data = '0;

        // T1: reset state
        repeat (3) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_addr", 64'(rf_addr), 64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_oaddr", 64'(out_addr), 64'd0);
        check("rst_odata", 64'(out_data), 64'd0);
        reset = 1'b0;
        step();
        $display("reset checked");

        // T2: clear over random contents, then dump zeros
        preload(1'b0);
        run_clear(1'b0, 0);
        run_dump(100, 1'b0);

        // T3 / T4: pattern dump, free-flowing then with a stall on word 3
        preload(1'b1);
        run_dump(100, 1'b0);
        run_dump(100, 1'b1);

        // Random contents under random backpressure
        preload(1'b0);
        run_dump(50, 1'b0);
        run_dump(25, 1'b0);

        // T5: simultaneous starts, dump poke mid-clear
        preload(1'b1);
        run_clear(1'b1, 10);
        run_dump(70, 1'b0);

        // T6: reset while word 10 is waiting
        preload(1'b1);
        start_dump = 1'b1;
        step();
        start_dump = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (out_valid && out_addr == 6'd10) break;
            step();
        end
        out_ready = 1'b0;
        check("t6_reached", 64'(out_addr), 64'd10);
        reset = 1'b1;
        step();
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_rf_addr", 64'(rf_addr), 64'd0);
        reset = 1'b0;
        step();
        $display("mid-send reset checked");
        run_dump(100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
